// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared constants for the input debouncer.
//                CLK_HZ               - board clock frequency
//                DEFAULT_TICK_DIV     - clk cycles per 1 ms sample tick
//                DEFAULT_STABLE_TICKS - ticks needed to accept a new level
//                DEFAULT_LONG_TICKS   - ticks of stable-high for long_press
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int CLK_HZ               = 100_000_000;
    localparam int DEFAULT_TICK_DIV     = 100_000;
    localparam int DEFAULT_STABLE_TICKS = 10;
    localparam int DEFAULT_LONG_TICKS   = 1000;

    // Counter width able to hold values 0..max_val, never narrower than 1 bit.
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_cell
//  Description : One-bit debounce cell: 2-flop synchroniser, tick-qualified
//                match counter, stable level flop and rise/fall pulses.
//                Optional hold counter producing a long_press pulse when
//                INPUT_DEBOUNCER_LONG_PRESS_EN is defined.
//  Ports       : clk_i         - clock
//                reset_ni      - asynchronous active-low reset
//                raw_i         - unsynchronised input pin
//                tick_i        - one-cycle sample strobe
//                stable_o      - debounced level
//                rise_o/fall_o - one-cycle edge pulses, coincident with the
//                                first cycle of the new level
//                long_press_o  - one-cycle long-hold pulse (0 if disabled)
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
`ifdef INPUT_DEBOUNCER_LONG_PRESS_EN
    ,
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS
`endif
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic raw_i,
    input  logic tick_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_press_o
);

    localparam int                c_cnt_w    = count_width(STABLE_TICKS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_TICKS - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic               stable_q, stable_d;
    logic               rise_q,   rise_d;
    logic               fall_q,   fall_d;
    logic [c_cnt_w-1:0] cnt_q,    cnt_d;

    // Any cycle of agreement restarts qualification, so a glitch shorter than
    // STABLE_TICKS full ticks can never move the stable level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == c_cnt_last) begin
                stable_d = sync2_q;
                cnt_d    = '0;
                rise_d   = sync2_q;
                fall_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

`ifdef INPUT_DEBOUNCER_LONG_PRESS_EN
    localparam int                 c_hold_w   = count_width(LONG_TICKS);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_TICKS);
    localparam logic [c_hold_w-1:0] c_hold_pre = c_hold_w'(LONG_TICKS - 1);

    logic [c_hold_w-1:0] hold_q, hold_d;
    logic                long_q, long_d;

    // Saturating at LONG_TICKS is what keeps the pulse from repeating until
    // the level drops and clears the counter.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!stable_q) begin
            hold_d = '0;
        end else if (tick_i && (hold_q != c_hold_max)) begin
            hold_d = hold_q + c_hold_w'(1);
            long_d = (hold_q == c_hold_pre);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule : debounce_cell
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Debounces WIDTH raw switch/button pins into clean levels with
//                single-cycle rise/fall pulses. One shared prescaler produces
//                a sample tick every TICK_DIV cycles; one debounce_cell per
//                bit. Optional long-press detection is built when the macro
//                INPUT_DEBOUNCER_LONG_PRESS_EN is defined; otherwise
//                long_press is tied to 0.
//  Ports       : clk        - 100 MHz board clock
//                reset_n    - asynchronous active-low reset
//                raw_in     - unsynchronised pins
//                stable     - debounced levels
//                rise/fall  - one-cycle edge pulses per bit
//                tick       - one-cycle sample strobe
//                long_press - one-cycle long-hold pulse per bit
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick,
    output logic [WIDTH-1:0] long_press
);

    generate
        if (TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_param_check
            $error("input_debouncer: TICK_DIV must be >= 2, STABLE_TICKS and LONG_TICKS >= 1");
        end
    endgenerate

    localparam int                 c_pre_w    = $clog2(TICK_DIV);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);

    logic [c_pre_w-1:0] pre_q, pre_d;
    logic               tick_q, tick_d;

    // tick is registered from the terminal count, so it lands in the cycle
    // after the prescaler reads TICK_DIV-1 and recurs every TICK_DIV cycles.
    always_comb begin
        tick_d = (pre_q == c_pre_last);
        pre_d  = tick_d ? '0 : pre_q + c_pre_w'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            debounce_cell #(
                .STABLE_TICKS (STABLE_TICKS)
`ifdef INPUT_DEBOUNCER_LONG_PRESS_EN
                ,
                .LONG_TICKS   (LONG_TICKS)
`endif
            ) u_cell (
                .clk_i        (clk),
                .reset_ni     (reset_n),
                .raw_i        (raw_in[i]),
                .tick_i       (tick_q),
                .stable_o     (stable[i]),
                .rise_o       (rise[i]),
                .fall_o       (fall[i]),
                .long_press_o (long_press[i])
            );
        end
    endgenerate

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Self-checking bench for input_debouncer with TICK_DIV=4,
//                STABLE_TICKS=3, LONG_TICKS=5. Long-press expectations follow
//                INPUT_DEBOUNCER_LONG_PRESS_EN as seen by this file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int W  = 16;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int LT = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] stable, rise, fall, long_press;
    logic         tick;

    int checks = 0;
    int errors = 0;

`ifdef INPUT_DEBOUNCER_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    input_debouncer #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .LONG_TICKS   (LT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .stable     (stable),
        .rise       (rise),
        .fall       (fall),
        .tick       (tick),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Time is counted in edges since reset release; a tick is visible after
    // every TD-th edge. Each bit tracks how many ticks its synchronised input
    // has disagreed with the accepted level without a single agreeing cycle.
    logic [W-1:0] m_s1, m_s2, m_stab, m_rise, m_fall, m_lp;
    logic         m_tick;
    int           m_k;
    int           m_run  [W];
    int           m_hold [W];

    task automatic model_step();
        logic [W-1:0] o_s2, o_stab;
        logic         o_tick;
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0; m_rise = '0; m_fall = '0;
            m_lp = '0; m_tick = 1'b0; m_k = 0;
            for (int b = 0; b < W; b++) begin
                m_run[b] = 0; m_hold[b] = 0;
            end
            return;
        end
        o_s2   = m_s2;
        o_stab = m_stab;
        o_tick = m_tick;
        m_s2   = m_s1;
        m_s1   = raw_in;
        m_k    = m_k + 1;
        m_tick = (m_k % TD == 0);
        m_rise = '0; m_fall = '0; m_lp = '0;
        for (int b = 0; b < W; b++) begin
            if (o_s2[b] == o_stab[b]) begin
                m_run[b] = 0;
            end else if (o_tick) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == ST) begin
                    m_stab[b] = o_s2[b];
                    m_run[b]  = 0;
                    if (o_s2[b]) m_rise[b] = 1'b1;
                    else         m_fall[b] = 1'b1;
                end
            end
            if (!o_stab[b]) begin
                m_hold[b] = 0;
            end else if (o_tick && m_hold[b] < LT) begin
                m_hold[b] = m_hold[b] + 1;
                if (m_hold[b] == LT) m_lp[b] = LP_EN;
            end
        end
    endtask

    // One clock: model follows the edge, outputs settle 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int lat;
        bit seen_prev;
        reset_n = 1'b0;
        raw_in  = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if ({stable, rise, fall, tick, long_press} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: stable=%h rise=%h fall=%h tick=%b lp=%h, required all 0",
                         stable, rise, fall, tick, long_press);
            end
        end
        reset_n   = 1'b1;
        lat       = 0;
        seen_prev = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            checks++;
            if (stable !== m_stab) begin
                errors++;
                $display("FAIL reset_release_stable: cycle %0d got %h, required %h", c, stable, m_stab);
            end
            if (seen_prev) begin
                checks++;
                if (rise !== '0) begin
                    errors++;
                    $display("FAIL reset_rise_width: got %h, required 0000", rise);
                end
                seen_prev = 1'b0;
            end
            if (lat == 0 && stable === 16'hFFFF) begin
                lat = c;
                seen_prev = 1'b1;
                checks++;
                if (rise !== 16'hFFFF || fall !== '0) begin
                    errors++;
                    $display("FAIL reset_first_rise: rise=%h fall=%h, required rise=ffff fall=0000", rise, fall);
                end
            end
        end
        checks++;
        if (lat < 1 || lat > 2 + 3 * TD) begin
            errors++;
            $display("FAIL reset_latency: got %0d cycles, required 1..%0d", lat, 2 + 3 * TD);
        end
    endtask

    task automatic test_glitch();
        int lat, nrise;
        raw_in = '0;
        repeat (20) cycle();
        for (int ph = 0; ph < 8; ph++) begin
            raw_in[3] = (ph % 2 == 0);
            for (int c = 0; c < 5; c++) begin
                cycle();
                checks++;
                if (stable[3] !== 1'b0 || rise[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_reject: stable[3]=%b rise[3]=%b, required 0 0", stable[3], rise[3]);
                end
            end
        end
        raw_in[3] = 1'b1;
        lat = 0; nrise = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (rise[3] === 1'b1) begin
                nrise++;
                if (lat == 0) lat = c;
            end
        end
        checks++;
        if (nrise != 1 || lat < 2 + 3 * TD - 3 || lat > 2 + 3 * TD) begin
            errors++;
            $display("FAIL glitch_final_rise: %0d pulses at cycle %0d, required 1 pulse at 11..14", nrise, lat);
        end
    endtask

    task automatic test_fall();
        int nfall, nrise;
        raw_in[3] = 1'b0;
        nfall = 0; nrise = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (fall[3] === 1'b1) nfall++;
            if (rise !== '0) nrise++;
            checks++;
            if ((stable & ~16'h0008) !== '0 || (fall & ~16'h0008) !== '0) begin
                errors++;
                $display("FAIL fall_others: stable=%h fall=%h, required other bits 0", stable, fall);
            end
        end
        checks++;
        if (stable[3] !== 1'b0 || nfall != 1 || nrise != 0) begin
            errors++;
            $display("FAIL fall_bit3: stable[3]=%b falls=%0d rises=%0d, required 0 1 0", stable[3], nfall, nrise);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] first;
        int           n;
        raw_in = 16'h8001;
        first = '0; n = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (rise !== '0) begin
                n++;
                if (first == '0) first = rise;
            end
        end
        checks++;
        if (first !== 16'h8001 || n != 1) begin
            errors++;
            $display("FAIL simultaneous_rise: first=%h cycles=%0d, required 8001 in 1 cycle", first, n);
        end
        raw_in = '0;
        repeat (20) cycle();
    endtask

    task automatic test_reset_mid();
        int  lat, guard;
        guard = 0;
        raw_in[5] = 1'b1;
        while (m_run[5] != 2 && guard < 40) begin
            cycle();
            guard++;
        end
        checks++;
        if (guard >= 40 || stable[5] !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_partial: run reached after %0d cycles, stable[5]=%b, required 2 ticks and 0",
                     guard, stable[5]);
        end
        reset_n = 1'b0;
        cycle();
        reset_n   = 1'b1;
        raw_in[5] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            checks++;
            if (stable !== '0 || rise !== '0 || fall !== '0) begin
                errors++;
                $display("FAIL resetmid_quiet: stable=%h rise=%h fall=%h, required 0", stable, rise, fall);
            end
        end
        raw_in[5] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (lat == 0 && stable[5] === 1'b1) lat = c;
        end
        checks++;
        if (lat < 2 + 3 * TD - 3 || lat > 2 + 3 * TD) begin
            errors++;
            $display("FAIL resetmid_requalify: got %0d cycles, required 11..14", lat);
        end
        raw_in = '0;
        repeat (20) cycle();
    endtask

    task automatic test_long_press();
        int r, lp, nlp, last_tick;
        r = 0; lp = 0; nlp = 0; last_tick = 0;
        raw_in[7] = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            cycle();
            if (r == 0 && rise[7] === 1'b1) r = c;
            if (long_press[7] === 1'b1) begin
                nlp++;
                if (lp == 0) lp = c;
            end
            if (tick === 1'b1) begin
                if (last_tick != 0) begin
                    checks++;
                    if (c - last_tick != TD) begin
                        errors++;
                        $display("FAIL tick_period: got %0d cycles, required %0d", c - last_tick, TD);
                    end
                end
                last_tick = c;
            end
        end
        checks++;
        if (LP_EN) begin
            if (r == 0 || nlp != 1 || lp - r != LT * TD) begin
                errors++;
                $display("FAIL long_press_once: pulses=%0d delay=%0d, required 1 pulse %0d cycles after rise",
                         nlp, lp - r, LT * TD);
            end
        end else if (nlp != 0) begin
            errors++;
            $display("FAIL long_press_disabled: got %0d pulses, required 0", nlp);
        end
        raw_in[7] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            checks++;
            if (long_press !== '0) begin
                errors++;
                $display("FAIL long_press_release: got %h, required 0000", long_press);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1200; n++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range((b < 8) ? 5 : 24, 0) == 0) raw_in[b] = ~raw_in[b];
            end
            cycle();
            checks++;
            if (stable !== m_stab) begin
                errors++;
                $display("FAIL rand_stable: cycle %0d got %h, required %h", n, stable, m_stab);
            end
            checks++;
            if (rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL rand_pulses: cycle %0d rise=%h fall=%h, required rise=%h fall=%h",
                         n, rise, fall, m_rise, m_fall);
            end
            checks++;
            if (tick !== m_tick) begin
                errors++;
                $display("FAIL rand_tick: cycle %0d got %b, required %b", n, tick, m_tick);
            end
            checks++;
            if (long_press !== m_lp) begin
                errors++;
                $display("FAIL rand_long_press: cycle %0d got %h, required %h", n, long_press, m_lp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_fall();
        test_simultaneous();
        test_reset_mid();
        test_long_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_input_debouncer
`default_nettype wire
